// File: rtl/d_format_issue_if.sv
// Handshake and decoded-field bundle between the instruction source/execute side and the issue unit.
// master drives instructions and out_ready; slave (the issue unit) returns decoded fields and status.
interface d_format_issue_if #(
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_instr;
    logic                     out_valid;
    logic                     out_ready;
    logic [5:0]               PO;
    logic [4:0]               rt;
    logic [4:0]               ra;
    logic [47:0]              SI;
    logic                     illegal;
    logic [7:0]               illegal_count;
    logic [$clog2(DEPTH):0]   fifo_count;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, PO, rt, ra, SI, illegal, illegal_count, fifo_count
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, PO, rt, ra, SI, illegal, illegal_count, fifo_count
    );
endinterface

// File: rtl/d_format_issue.sv
// D-format issue unit: FIFO -> decode -> output register; one-edge latency from push to out_valid.
// in_ready drops when the FIFO is full; the output register holds while out_valid && !out_ready.
module d_format_issue #(
    parameter int DEPTH      = 4,
    parameter int HAZARD_GAP = 2
) (
    input logic               clk,
    input logic               rst,
    d_format_issue_if.slave   io
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = (HAZARD_GAP < 2) ? 1 : $clog2(HAZARD_GAP + 1);

    localparam logic [5:0] PO_ADDI = 6'd14;
    localparam logic [5:0] PO_ORI  = 6'd24;
    localparam logic [5:0] PO_ANDI = 6'd28;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [5:0]    po_q, po_d;
    logic [4:0]    rt_q, rt_d, ra_q, ra_d;
    logic [47:0]   si_q, si_d;
    logic [7:0]    ill_cnt_q, ill_cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [4:0]    last_rt_q, last_rt_d;
    logic [1:0]    state_q, state_d;

    logic [31:0] head;
    logic [47:0] si_ext;
    logic        head_vld, head_legal, hazard, push, drop, load;

    assign head       = mem_q[rd_ptr_q];
    assign head_vld   = (cnt_q != '0);
    assign head_legal = (head[31:26] == PO_ADDI) || (head[31:26] == PO_ORI) || (head[31:26] == PO_ANDI);
    // ra==0 reads a literal zero, so it never depends on a producer
    assign hazard     = (gap_q != '0) && (head[20:16] != 5'd0) && (head[20:16] == last_rt_q);
    assign si_ext     = (head[31:26] == PO_ADDI) ? {{32{head[15]}}, head[15:0]} : {32'd0, head[15:0]};
    assign push       = io.in_valid && io.in_ready;
    assign drop       = head_vld && !head_legal;
    assign load       = head_vld && head_legal && (!out_valid_q || io.out_ready) && !hazard;

    assign io.in_ready      = (cnt_q < CW'(DEPTH));
    assign io.out_valid     = out_valid_q;
    assign io.PO            = po_q;
    assign io.rt            = rt_q;
    assign io.ra            = ra_q;
    assign io.SI            = si_q;
    assign io.illegal       = drop;
    assign io.illegal_count = ill_cnt_q;
    assign io.fifo_count    = cnt_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + CW'(push) - CW'(drop || load);
        out_valid_d = out_valid_q;
        po_d        = po_q;
        rt_d        = rt_q;
        ra_d        = ra_q;
        si_d        = si_q;
        ill_cnt_d   = ill_cnt_q;
        gap_d       = gap_q;
        last_rt_d   = last_rt_q;
        state_d     = state_q;

        if (push)
            wr_ptr_d = wr_ptr_q + PW'(1);
        if (drop || load)
            rd_ptr_d = rd_ptr_q + PW'(1);

        if (load) begin
            out_valid_d = 1'b1;
            po_d        = head[31:26];
            rt_d        = head[25:21];
            ra_d        = head[20:16];
            si_d        = si_ext;
            last_rt_d   = head[25:21];
            gap_d       = GW'(HAZARD_GAP);
        end else begin
            if (io.out_ready)
                out_valid_d = 1'b0;
            if (gap_q != '0)
                gap_d = gap_q - GW'(1);
        end

        if (drop && (ill_cnt_q != 8'hFF))
            ill_cnt_d = ill_cnt_q + 8'd1;

        case (state_q)
            S_IDLE:  if (head_vld && head_legal) state_d = hazard ? S_STALL : S_ISSUE;
            S_ISSUE: begin
                if (head_vld && head_legal && hazard)
                    state_d = S_STALL;
                else if (!out_valid_d && (cnt_d == '0))
                    state_d = S_IDLE;
            end
            S_STALL: if (gap_d == '0) state_d = S_ISSUE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= io.in_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            po_q        <= '0;
            rt_q        <= '0;
            ra_q        <= '0;
            si_q        <= '0;
            ill_cnt_q   <= '0;
            gap_q       <= '0;
            last_rt_q   <= '0;
            state_q     <= S_IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            po_q        <= po_d;
            rt_q        <= rt_d;
            ra_q        <= ra_d;
            si_q        <= si_d;
            ill_cnt_q   <= ill_cnt_d;
            gap_q       <= gap_d;
            last_rt_q   <= last_rt_d;
            state_q     <= state_d;
        end
    end
endmodule

// File: tb/tb_d_format_issue.sv
// Bench for d_format_issue: directed scenarios plus randomized traffic against an in-order
// issue queue model with hazard-spacing and hold-stability checks.
module tb_d_format_issue;
    localparam int DEPTH = 4;
    localparam int HG    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    d_format_issue_if #(.DEPTH(DEPTH)) io ();

    d_format_issue #(.DEPTH(DEPTH), .HAZARD_GAP(HG)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] exp_q [$];
    int          exp_ill  = 0;
    int          ill_seen = 0;
    int          ld_cyc [$];
    logic [63:0] ld_dat [$];
    bit          have_prev = 0;
    logic [4:0]  prev_rt;
    int          prev_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_po(input logic [5:0] po);
        return (po == 6'd14) || (po == 6'd24) || (po == 6'd28);
    endfunction

    // Reference decode: ADDI sign-extends, ANDI/ORI zero-extend.
    function automatic logic [63:0] bundle_of(input logic [31:0] w);
        logic [47:0] si;
        if (w[31:26] == 6'd14) si = 48'($signed(w[15:0]));
        else                   si = 48'(w[15:0]);
        return {w[31:26], w[25:21], w[20:16], si};
    endfunction

    function automatic logic [63:0] ld_at(input int i);
        if (i >= 0 && i < ld_dat.size()) return ld_dat[i];
        return '1;
    endfunction

    function automatic int ld_cyc_at(input int i);
        if (i >= 0 && i < ld_cyc.size()) return ld_cyc[i];
        return -1000;
    endfunction

    task automatic step();
        logic        pv, pr;
        logic [63:0] held, cur;
        logic [31:0] w;
        pv   = io.out_valid;
        pr   = io.out_ready;
        held = {io.PO, io.rt, io.ra, io.SI};
        if (io.illegal) ill_seen++;
        if (io.in_valid && io.in_ready && !rst) begin
            if (legal_po(io.in_instr[31:26])) exp_q.push_back(io.in_instr);
            else                              exp_ill++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) return;
        cur = {io.PO, io.rt, io.ra, io.SI};
        if (pv && !pr) begin
            chk("hold_valid", io.out_valid, 1);
            chk("hold_fields", cur, held);
        end else if (io.out_valid) begin
            ld_cyc.push_back(cyc);
            ld_dat.push_back(cur);
            chk("issue_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("issue_order", cur, bundle_of(w));
            end
            if (have_prev && io.ra != 5'd0 && io.ra == prev_rt)
                chk("hazard_gap", (cyc - prev_cyc) > HG, 1);
            have_prev = 1;
            prev_rt   = io.rt;
            prev_cyc  = cyc;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push_word(input logic [31:0] w);
        int t = 0;
        io.in_valid = 1'b1;
        io.in_instr = w;
        while (!io.in_ready && t < 50) begin
            step();
            t++;
        end
        chk("push_wait", t < 50, 1);
        step();
        io.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_ill   = 0;
        have_prev = 0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_in_ready"}, io.in_ready, 1);
        chk({pfx, "_out_valid"}, io.out_valid, 0);
        chk({pfx, "_fields"}, {io.PO, io.rt, io.ra, io.SI}, 64'd0);
        chk({pfx, "_illegal"}, io.illegal, 0);
        chk({pfx, "_ill_cnt"}, io.illegal_count, 0);
        chk({pfx, "_fifo_cnt"}, io.fifo_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0, i0, t;
        logic [63:0] b;
        logic [5:0]  po;
        int          r;

        io.in_valid  = 1'b0;
        io.in_instr  = '0;
        io.out_ready = 1'b1;
        do_reset();
        do_reset();
        chk_reset_vals("rst0");

        // Latency and ADDI decode
        push_word(32'h38EC000A);
        chk("lat_ov0", io.out_valid, 0);
        chk("lat_cnt1", io.fifo_count, 1);
        step();
        chk("lat_ov1", io.out_valid, 1);
        chk("lat_po", io.PO, 14);
        chk("lat_rt", io.rt, 7);
        chk("lat_ra", io.ra, 12);
        chk("lat_si", io.SI, 10);
        idle(4);

        // Immediate extension
        n0 = ld_dat.size();
        push_word(32'h70EC8000);
        push_word(32'h38ECFFF6);
        idle(4);
        chk("ext_issued", ld_dat.size() - n0, 2);
        b = ld_at(n0);
        chk("andi_si", b[47:0], 48'h000000008000);
        b = ld_at(n0 + 1);
        chk("addi_neg_si", b[47:0], 48'hFFFFFFFFFFF6);
        idle(4);

        // RAW hazard: dependent consumer, then ra=0 consumer
        n0 = ld_cyc.size();
        push_word(32'h38EC000A);
        push_word(32'h39070001);
        idle(6);
        chk("dep_issued", ld_cyc.size() - n0, 2);
        chk("dep_bubbles", ld_cyc_at(n0 + 1) - ld_cyc_at(n0) - 1, HG);
        idle(4);
        n0 = ld_cyc.size();
        push_word(32'h38EC000A);
        push_word(32'h39000001);
        idle(4);
        chk("ra0_issued", ld_cyc.size() - n0, 2);
        chk("ra0_bubbles", ld_cyc_at(n0 + 1) - ld_cyc_at(n0) - 1, 0);
        idle(4);

        // Illegal word between two ORIs
        n0 = ld_dat.size();
        i0 = ill_seen;
        push_word(32'h60EC000A);
        push_word(32'hFC000000);
        push_word(32'h60EC000A);
        idle(4);
        chk("ill_pulses", ill_seen - i0, 1);
        chk("ill_count", io.illegal_count, 1);
        chk("ill_ori_issued", ld_dat.size() - n0, 2);
        b = ld_at(n0 + 1);
        chk("ill_ori2_po", b[63:58], 24);
        idle(4);

        // Backpressure: five words, depth four
        n0 = ld_dat.size();
        io.out_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            push_word({6'd14, 5'(k + 1), 5'd0, 16'(k * 3)});
        chk("bp_cnt", io.fifo_count, 4);
        chk("bp_in_ready", io.in_ready, 0);
        chk("bp_ov", io.out_valid, 1);
        chk("bp_rt", io.rt, 1);
        idle(3);
        chk("bp_cnt_hold", io.fifo_count, 4);
        io.out_ready = 1'b1;
        t = 0;
        while ((ld_dat.size() - n0) < 5 && t < 30) begin
            step();
            t++;
        end
        chk("bp_all_issued", ld_dat.size() - n0, 5);
        for (int k = 0; k < 5; k++) begin
            b = ld_at(n0 + k);
            chk("bp_rt_order", b[57:53], k + 1);
        end
        idle(4);

        // Reset with three words buffered
        io.out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            push_word({6'd24, 5'(k + 10), 5'd0, 16'(k)});
        chk("rst_pre_cnt", io.fifo_count, 3);
        do_reset();
        chk_reset_vals("rst1");
        io.out_ready = 1'b1;
        n0 = ld_dat.size();
        idle(10);
        chk("rst_no_issue", ld_dat.size() - n0, 0);

        // Randomized traffic
        i0 = ill_seen;
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 99));
            if (r < 28)      po = 6'd14;
            else if (r < 56) po = 6'd24;
            else if (r < 85) po = 6'd28;
            else begin
                po = 6'($urandom);
                if (legal_po(po)) po = 6'd0;
            end
            io.in_valid  = ($urandom_range(0, 9) < 7);
            io.in_instr  = {po, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
            io.out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        idle(6);
        chk("rand_drain", exp_q.size(), 0);
        chk("rand_fifo_empty", io.fifo_count, 0);
        chk("rand_out_idle", io.out_valid, 0);
        chk("rand_ill_pulses", ill_seen - i0, exp_ill);
        chk("rand_ill_count", io.illegal_count, (exp_ill > 255) ? 255 : exp_ill);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
